conv_engine: RTL and testbench
==============================

// Module: conv_engine
// PURPOSE
//  Parametrised successor to the fixed 3x3 convolution processor; a single block with an internal FSM.
//  Sweeps every pixel of a stored image and applies a selectable KSIZE x KSIZE signed kernel.
//  Normalises each sum by a run-time right shift, clamps it to pixel range and writes it to the output frame buffer.
//  Sits between the kernel ROM, the source pixel RAM and the output (display) RAM.
// PARAMETERS
//  PIX_W   3    pixel width, unsigned
//  COEF_W  5    kernel coefficient width, signed two's complement
//  KSIZE   3    kernel side; legal values 3 or 5 only
//  NKER    8    number of kernels in the kernel ROM
//  IMG_W   160  image width in pixels
//  IMG_H   120  image height in pixels
//  X_W     8    x address width, >= clog2(IMG_W)
//  Y_W     7    y address width, >= clog2(IMG_H)
//  Derived localparams:
//   NTAP = KSIZE*KSIZE
//   KA_W = clog2(NKER*NTAP)
//   ACC_W = PIX_W+COEF_W+1+clog2(NTAP)
// PORTS
//  clk        in   1       clock; all logic on the rising edge
//  rst        in   1       reset, synchronous, active-high
//  start      in   1       one-cycle request to begin a frame; ignored unless idle
//  abort      in   1       stop the run; return to IDLE, done not asserted
//  ker_sel    in   clog2(NKER)  kernel index; latched on an accepted start
//  shift      in   4       normalisation right shift; latched on an accepted start
//  border     in   1       0 = zero padding, 1 = replicate edge; latched on an accepted start
//  busy       out  1       high from the cycle after an accepted start until done/abort
//  done       out  1       one-cycle pulse after the last output write
//  ker_addr   out  KA_W    kernel ROM address = ker_sel*NTAP + tap
//  ker_din    in   COEF_W  kernel ROM data; valid 1 cycle after ker_addr
//  rd_x       out  X_W     source pixel column
//  rd_y       out  Y_W     source pixel row
//  pix_din    in   PIX_W   source pixel data; valid 1 cycle after rd_x/rd_y
//  out_we     out  1       output write strobe, one cycle per pixel
//  out_x      out  X_W     output pixel column
//  out_y      out  Y_W     output pixel row
//  out_pix    out  PIX_W   output pixel value
// BEHAVIOUR
//  Reset: every output is 0, FSM in IDLE, coefficient registers cleared.
//  States: IDLE -> LOAD -> TAP -> LAST -> NORM -> WRITE -> (TAP | FIN) -> IDLE.
//  IDLE:
//   - start latches ker_sel, shift and border, then goes to LOAD.
//   - start while busy has no effect.
//  LOAD:
//   - Issues ker_addr for taps 0..NTAP-1, one per cycle.
//   - Captures ker_din into coef[t] one cycle later.
//   - Lasts NTAP+1 cycles.
//  TAP:
//   - Issues one window read per cycle, raster order (dy outer, dx inner), dx,dy in -R..R with R = KSIZE/2.
//   - acc += coef[t-1]*pix_din for the previous tap (pipelined); acc is cleared on tap 0.
//  Border:
//   - A tap coordinate outside [0,IMG_W-1] x [0,IMG_H-1] is clamped to the edge for the address.
//   - Zero mode: that tap's operand is forced to 0. Replicate mode: the clamped pixel is used.
//  LAST: accumulates the final tap.
//  NORM:
//   - v = acc >>> shift (arithmetic).
//   - v < 0 gives 0; v > 2^PIX_W-1 gives 2^PIX_W-1; otherwise v. Result registered into out_pix.
//  WRITE:
//   - out_we = 1 for exactly one cycle with out_x/out_y = the current centre pixel.
//   - Centre advances x first; x wraps IMG_W-1 -> 0 and y increments.
//   - After (IMG_W-1, IMG_H-1), go to FIN.
//  FIN: done = 1 for one cycle, busy drops in the same cycle, then IDLE.
//  Throughput: NTAP+3 cycles per pixel.
//   - Frame latency = NTAP+1 + IMG_W*IMG_H*(NTAP+3) + 1 cycles from start to done.
//  Widths:
//   - Products are signed, PIX_W+COEF_W+1 bits (pixel zero-extended).
//   - The accumulator never overflows at ACC_W.
//  Abort or rst mid-frame:
//   - Next cycle IDLE, busy = 0, no further out_we, no done pulse.
//   - A write in the same cycle as abort still completes.
//  abort and start in the same cycle while IDLE: abort wins, the start is dropped.
//  out_x/out_y/out_pix hold their last values when out_we = 0.
// STRUCTURE
//  Shared package conv_pkg:
//   - FSM state encodings (IDLE, LOAD, TAP, LAST, NORM, WRITE, FIN).
//   - Border mode constants BORDER_ZERO = 0, BORDER_REPL = 1.
//   - clog2 function.
//  One sub-module, conv_win_addr:
//   - Combinational tap offset + centre -> clamped rd_x/rd_y plus an out-of-range flag.
//   - Instantiated once.
//  FSM, coefficient register file, MAC and clamp stay in conv_engine.
// TESTING
//  1. Identity kernel (centre=1, others 0), shift=0, 4x3 ramp image -> out frame equals source; done at cycle 10+12*12+1.
//  2. All-ones 3x3, shift=3, border=0, constant image 7 -> interior pixels 7 (63>>3); corner (0,0) = 3 (28>>3).
//  3. Same as 2 with border=1 -> every pixel 7, including corners.
//  4. Negative kernel (centre=-1), image 5 -> all outputs 0; kernel of all +15 on image 7, shift=0 -> all outputs 7 (clamp).
//  5. start pulsed during busy -> ignored, single done; abort at pixel 5 -> no out_we afterwards, no done, busy=0 next cycle.
//  6. rst asserted mid-TAP -> all outputs 0 next cycle; a new start runs a full correct frame; repeat 1-3 with KSIZE=5.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM encodings, border constants and helpers for the convolution engine
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TAP   = 3'd2,
        LAST  = 3'd3,
        NORM  = 3'd4,
        WRITE = 3'd5,
        FIN   = 3'd6
    } state_t;

    localparam logic BORDER_ZERO = 1'b0;
    localparam logic BORDER_REPL = 1'b1;

    // Ceiling log2 for sizing address and counter fields.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/conv_engine_if.sv
// rtl/conv_engine_if.sv - memory-side bus of the convolution engine (kernel ROM, source RAM, output RAM)
interface conv_engine_if #(
    parameter int PIX_W  = 3,
    parameter int COEF_W = 5,
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int KA_W   = 7
);
    logic [KA_W-1:0]   ker_addr;
    logic [COEF_W-1:0] ker_din;
    logic [X_W-1:0]    rd_x;
    logic [Y_W-1:0]    rd_y;
    logic [PIX_W-1:0]  pix_din;
    logic              out_we;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    logic [PIX_W-1:0]  out_pix;

    modport master (
        output ker_addr, input ker_din,
        output rd_x, output rd_y, input pix_din,
        output out_we, output out_x, output out_y, output out_pix
    );

    modport slave (
        input ker_addr, output ker_din,
        input rd_x, input rd_y, output pix_din,
        input out_we, input out_x, input out_y, input out_pix
    );
endinterface

// File: rtl/conv_win_addr.sv
// rtl/conv_win_addr.sv - window tap offset plus centre to edge-clamped read address and out-of-range flag
module conv_win_addr #(
    parameter int KSIZE = 3,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int K_W   = 2
) (
    input  logic [X_W-1:0] cx,
    input  logic [Y_W-1:0] cy,
    input  logic [K_W-1:0] tx,
    input  logic [K_W-1:0] ty,
    output logic [X_W-1:0] rd_x,
    output logic [Y_W-1:0] rd_y,
    output logic           oor
);
    localparam int R = KSIZE / 2;

    logic signed [X_W+1:0] sx;
    logic signed [Y_W+1:0] sy;
    logic x_lo, x_hi, y_lo, y_hi;

    // Two spare bits keep centre+offset-R signed and unwrapped so both edges are detectable.
    always_comb begin
        sx   = $signed({2'b00, cx}) + $signed((X_W+2)'(tx)) - (X_W+2)'(R);
        sy   = $signed({2'b00, cy}) + $signed((Y_W+2)'(ty)) - (Y_W+2)'(R);
        x_lo = sx < 0;
        x_hi = sx > (X_W+2)'(IMG_W - 1);
        y_lo = sy < 0;
        y_hi = sy > (Y_W+2)'(IMG_H - 1);
        rd_x = x_lo ? '0 : (x_hi ? X_W'(IMG_W - 1) : sx[X_W-1:0]);
        rd_y = y_lo ? '0 : (y_hi ? Y_W'(IMG_H - 1) : sy[Y_W-1:0]);
        oor  = x_lo | x_hi | y_lo | y_hi;
    end
endmodule

// File: rtl/conv_engine.sv
// rtl/conv_engine.sv - frame-sweeping KSIZE x KSIZE convolution with shift normalisation and clamp
module conv_engine
    import conv_pkg::*;
#(
    parameter int PIX_W  = 3,
    parameter int COEF_W = 5,
    parameter int KSIZE  = 3,
    parameter int NKER   = 8,
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int X_W    = 8,
    parameter int Y_W    = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [clog2(NKER)-1:0]  ker_sel,
    input  logic [3:0]              shift,
    input  logic                    border,
    output logic                    busy,
    output logic                    done,
    conv_engine_if.master           mem
);
    localparam int NTAP    = KSIZE * KSIZE;
    localparam int KA_W    = clog2(NKER * NTAP);
    localparam int KS_W    = clog2(NKER);
    localparam int PROD_W  = PIX_W + COEF_W + 1;
    localparam int ACC_W   = PIX_W + COEF_W + 1 + clog2(NTAP);
    localparam int CNT_W   = clog2(NTAP + 1);
    localparam int K_W     = clog2(KSIZE);
    localparam int PIX_MAX = (1 << PIX_W) - 1;

    state_t state, nstate;

    logic [KS_W-1:0]          ksel_q;
    logic [3:0]               shift_q;
    logic                     border_q;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         tap_q;
    logic [K_W-1:0]           tx, ty;
    logic [X_W-1:0]           cx, out_x_q;
    logic [Y_W-1:0]           cy, out_y_q;
    logic [PIX_W-1:0]         out_pix_q;
    logic signed [COEF_W-1:0] coef [NTAP];
    logic signed [ACC_W-1:0]  acc;
    logic                     oor, oor_q;
    logic [X_W-1:0]           win_x;
    logic [Y_W-1:0]           win_y;
    logic                     last_pix;

    logic [PIX_W-1:0]         op;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  norm_v;
    logic [PIX_W-1:0]         norm_pix;

    conv_win_addr #(
        .KSIZE(KSIZE), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .X_W(X_W), .Y_W(Y_W), .K_W(K_W)
    ) u_win (
        .cx(cx), .cy(cy), .tx(tx), .ty(ty),
        .rd_x(win_x), .rd_y(win_y), .oor(oor)
    );

    assign last_pix      = (cx == X_W'(IMG_W - 1)) && (cy == Y_W'(IMG_H - 1));
    assign mem.ker_addr  = KA_W'(ksel_q) * KA_W'(NTAP) + KA_W'(cnt);
    assign mem.rd_x      = win_x;
    assign mem.rd_y      = win_y;
    assign mem.out_x     = out_x_q;
    assign mem.out_y     = out_y_q;
    assign mem.out_pix   = out_pix_q;

    // State register; abort overrides everything, including a same-cycle start.
    always_ff @(posedge clk) begin
        if (rst || abort) state <= IDLE;
        else              state <= nstate;
    end

    // Next-state logic.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = LOAD;
            LOAD:    if (cnt == CNT_W'(NTAP)) nstate = TAP;
            TAP:     if (cnt == CNT_W'(NTAP - 1)) nstate = LAST;
            LAST:    nstate = NORM;
            NORM:    nstate = WRITE;
            WRITE:   nstate = last_pix ? FIN : TAP;
            FIN:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Control outputs decoded from the state; busy is already low in FIN.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem.out_we = 1'b0;
        case (state)
            LOAD, TAP, LAST, NORM: busy = 1'b1;
            WRITE: begin
                busy       = 1'b1;
                mem.out_we = 1'b1;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // MAC operand for the tap addressed last cycle; zero padding kills out-of-frame taps.
    always_comb begin
        op       = (border_q == BORDER_ZERO && oor_q) ? '0 : mem.pix_din;
        coef_sel = (tap_q < CNT_W'(NTAP)) ? coef[tap_q] : '0;
        prod     = PROD_W'($signed({1'b0, op})) * PROD_W'(coef_sel);
    end

    // Arithmetic shift then clamp into pixel range.
    always_comb begin
        norm_v = acc >>> shift_q;
        if (norm_v < 0)                       norm_pix = '0;
        else if (norm_v > ACC_W'(PIX_MAX))    norm_pix = PIX_W'(PIX_MAX);
        else                                  norm_pix = norm_v[PIX_W-1:0];
    end

    // Datapath: run parameters, coefficient load, window walk, accumulate, output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ksel_q    <= '0;
            shift_q   <= '0;
            border_q  <= BORDER_ZERO;
            cnt       <= '0;
            tap_q     <= '0;
            tx        <= '0;
            ty        <= '0;
            cx        <= '0;
            cy        <= '0;
            acc       <= '0;
            oor_q     <= 1'b0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_pix_q <= '0;
            for (int i = 0; i < NTAP; i++) coef[i] <= '0;
        end else begin
            tap_q <= cnt;
            oor_q <= oor;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        ksel_q   <= ker_sel;
                        shift_q  <= shift;
                        border_q <= border;
                        cnt      <= '0;
                        tx       <= '0;
                        ty       <= '0;
                        cx       <= '0;
                        cy       <= '0;
                    end
                end
                LOAD: begin
                    if (cnt != '0) coef[cnt - CNT_W'(1)] <= mem.ker_din;
                    cnt <= (cnt == CNT_W'(NTAP)) ? '0 : cnt + CNT_W'(1);
                end
                TAP: begin
                    if (cnt == '0) acc <= '0;
                    else           acc <= acc + ACC_W'(prod);
                    cnt <= (cnt == CNT_W'(NTAP - 1)) ? '0 : cnt + CNT_W'(1);
                    if (tx == K_W'(KSIZE - 1)) begin
                        tx <= '0;
                        ty <= (ty == K_W'(KSIZE - 1)) ? '0 : ty + K_W'(1);
                    end else begin
                        tx <= tx + K_W'(1);
                    end
                end
                LAST: acc <= acc + ACC_W'(prod);
                NORM: begin
                    out_pix_q <= norm_pix;
                    out_x_q   <= cx;
                    out_y_q   <= cy;
                end
                WRITE: begin
                    if (cx == X_W'(IMG_W - 1)) begin
                        cx <= '0;
                        cy <= (cy == Y_W'(IMG_H - 1)) ? '0 : cy + Y_W'(1);
                    end else begin
                        cx <= cx + X_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_engine.sv
// tb/tb_conv_engine.sv - scoreboard bench for conv_engine, 3x3 and 5x5 instances on a 4x3 image
module tb_conv_engine;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int KA3 = conv_pkg::clog2(8 * 9);
    localparam int KA5 = conv_pkg::clog2(8 * 25);

    logic       clk = 1'b0;
    logic       rst;
    logic       start3, start5, abort, border;
    logic [2:0] ker_sel;
    logic [3:0] shift;
    logic       busy3, done3, busy5, done5;

    int img  [H][W];
    int got3 [H][W];
    int got5 [H][W];
    logic [4:0] rom3 [72];
    logic [4:0] rom5 [200];
    int q3[$];
    int q5[$];
    int wr3 = 0, wr5 = 0;
    int n_pass = 0, n_chk = 0;

    always #5 clk = ~clk;

    conv_engine_if #(.PIX_W(3), .COEF_W(5), .X_W(8), .Y_W(7), .KA_W(KA3)) m3 ();
    conv_engine_if #(.PIX_W(3), .COEF_W(5), .X_W(8), .Y_W(7), .KA_W(KA5)) m5 ();

    conv_engine #(.PIX_W(3), .COEF_W(5), .KSIZE(3), .NKER(8), .IMG_W(W), .IMG_H(H), .X_W(8), .Y_W(7)) u3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort), .ker_sel(ker_sel), .shift(shift),
        .border(border), .busy(busy3), .done(done3), .mem(m3));

    conv_engine #(.PIX_W(3), .COEF_W(5), .KSIZE(5), .NKER(8), .IMG_W(W), .IMG_H(H), .X_W(8), .Y_W(7)) u5 (
        .clk(clk), .rst(rst), .start(start5), .abort(abort), .ker_sel(ker_sel), .shift(shift),
        .border(border), .busy(busy5), .done(done5), .mem(m5));

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic int pk(input int x, input int y, input int p);
        return (x << 16) | (y << 8) | p;
    endfunction

    // Kernels: 0 identity, 1 all ones, 2 centre -1, 3 all +15, others a small mixed pattern.
    function automatic int kcoef(input int k, input int t, input int ntap);
        case (k)
            0:       return (t == ntap / 2) ? 1 : 0;
            1:       return 1;
            2:       return (t == ntap / 2) ? -1 : 0;
            3:       return 15;
            default: return (t % 3) - 1;
        endcase
    endfunction

    function automatic int model(input int ksz, input int k, input int sh, input int bd, input int x, input int y);
        int r, s, px, py, p;
        bit outside;
        r = ksz / 2;
        s = 0;
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                px = x + dx;
                py = y + dy;
                outside = (px < 0) || (px >= W) || (py < 0) || (py >= H);
                if (px < 0) px = 0;
                if (px >= W) px = W - 1;
                if (py < 0) py = 0;
                if (py >= H) py = H - 1;
                p = (outside && bd == 0) ? 0 : img[py][px];
                s = s + kcoef(k, (dy + r) * ksz + (dx + r), ksz * ksz) * p;
            end
        end
        s = s >>> sh;
        if (s < 0) s = 0;
        if (s > 7) s = 7;
        return s;
    endfunction

    task automatic fill(input int ramp, input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = ramp ? ((y * W + x) & 7) : v;
    endtask

    // Memory models: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        m3.pix_din <= 3'(img[m3.rd_y][m3.rd_x]);
        m5.pix_din <= 3'(img[m5.rd_y][m5.rd_x]);
        m3.ker_din <= (int'(m3.ker_addr) < 72)  ? rom3[m3.ker_addr] : 5'd0;
        m5.ker_din <= (int'(m5.ker_addr) < 200) ? rom5[m5.ker_addr] : 5'd0;
    end

    // Monitors: every output write is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (m3.out_we) begin
            wr3++;
            if (m3.out_x < 8'd4 && m3.out_y < 7'd3) got3[m3.out_y][m3.out_x] = int'(m3.out_pix);
            if (q3.size() == 0) check("dut3 unexpected write", 1, 0);
            else check("dut3 write", pk(int'(m3.out_x), int'(m3.out_y), int'(m3.out_pix)), q3.pop_front());
        end
        if (m5.out_we) begin
            wr5++;
            if (m5.out_x < 8'd4 && m5.out_y < 7'd3) got5[m5.out_y][m5.out_x] = int'(m5.out_pix);
            if (q5.size() == 0) check("dut5 unexpected write", 1, 0);
            else check("dut5 write", pk(int'(m5.out_x), int'(m5.out_y), int'(m5.out_pix)), q5.pop_front());
        end
    end

    task automatic run_frame(input int k, input int sh, input int bd, input bit en3, input bit en5, input int restart_at);
        int c, d3c, d5c, n3, n5;
        ker_sel = 3'(k);
        shift   = 4'(sh);
        border  = bd[0];
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (en3) q3.push_back(pk(x, y, model(3, k, sh, bd, x, y)));
                if (en5) q5.push_back(pk(x, y, model(5, k, sh, bd, x, y)));
            end
        @(posedge clk); #1 start3 = en3; start5 = en5;
        @(posedge clk); #1 start3 = 1'b0; start5 = 1'b0;
        c = 0; d3c = -1; d5c = -1; n3 = 0; n5 = 0;
        while (c < 600) begin
            @(negedge clk);
            c++;
            if (c == restart_at) start3 = 1'b1;
            if (c == restart_at + 1) start3 = 1'b0;
            if (c == 1 && en3) check("busy3 after start", int'(busy3), 1);
            if (c == 1 && en5) check("busy5 after start", int'(busy5), 1);
            if (done3) begin
                n3++;
                if (d3c < 0) d3c = c;
                check("busy3 low at done", int'(busy3), 0);
            end
            if (done5) begin
                n5++;
                if (d5c < 0) d5c = c;
                check("busy5 low at done", int'(busy5), 0);
            end
        end
        if (en3) begin
            check("done3 cycle", d3c, 10 + 12 * 12 + 1);
            check("done3 pulses", n3, 1);
            check("q3 drained", q3.size(), 0);
        end
        if (en5) begin
            check("done5 cycle", d5c, 26 + 12 * 28 + 1);
            check("done5 pulses", n5, 1);
            check("q5 drained", q5.size(), 0);
        end
    endtask

    initial begin
        int c, n, w0;
        rst = 1'b1; start3 = 1'b0; start5 = 1'b0; abort = 1'b0;
        ker_sel = '0; shift = '0; border = 1'b0;
        fill(0, 0);
        for (int k = 0; k < 8; k++) begin
            for (int t = 0; t < 9; t++)  rom3[k * 9 + t]  = 5'(kcoef(k, t, 9));
            for (int t = 0; t < 25; t++) rom5[k * 25 + t] = 5'(kcoef(k, t, 25));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy3", int'(busy3), 0);
        check("reset done3", int'(done3), 0);
        check("reset out_we3", int'(m3.out_we), 0);
        check("reset out_pix3", int'(m3.out_pix), 0);
        check("reset ker_addr3", int'(m3.ker_addr), 0);
        check("reset busy5", int'(busy5), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Identity on a ramp reproduces the source.
        fill(1, 0);
        run_frame(0, 0, 0, 1'b1, 1'b1, -1);
        check("hold out_pix3", int'(m3.out_pix), 3);
        check("hold out_pix5", int'(m5.out_pix), 3);

        // All-ones, shift 3, zero padding.
        fill(0, 7);
        run_frame(1, 3, 0, 1'b1, 1'b1, -1);
        check("zero corner3", got3[0][0], 3);
        check("zero edge3", got3[0][1], 5);
        check("zero interior3", got3[1][1], 7);
        check("zero corner5", got5[0][0], 7);

        // Same with edge replication.
        run_frame(1, 3, 1, 1'b1, 1'b1, -1);
        check("repl corner3", got3[0][0], 7);
        check("repl far corner3", got3[2][3], 7);
        check("repl corner5", got5[0][0], 7);

        // Negative result clamps to 0, overflow clamps to 7.
        fill(0, 5);
        run_frame(2, 0, 0, 1'b1, 1'b1, -1);
        check("neg clamp3", got3[1][1], 0);
        fill(0, 7);
        run_frame(3, 0, 0, 1'b1, 1'b1, -1);
        check("pos clamp3", got3[0][0], 7);
        check("pos clamp5", got5[1][1], 7);

        // Start while busy is ignored.
        fill(1, 0);
        run_frame(0, 0, 0, 1'b1, 1'b0, 50);

        // Abort after five writes.
        fill(0, 7);
        ker_sel = 3'd1; shift = 4'd3; border = 1'b1;
        for (int p = 0; p < 5; p++) q3.push_back(pk(p % W, p / W, 7));
        w0 = wr3;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        c = 0;
        while (wr3 < w0 + 5 && c < 400) begin
            @(posedge clk);
            c++;
        end
        check("abort writes before", wr3 - w0, 5);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("busy3 after abort", int'(busy3), 0);
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (done3) n++;
        end
        check("no done after abort", n, 0);
        check("no writes after abort", wr3 - w0, 5);
        check("abort q3 drained", q3.size(), 0);

        // Abort and start together while idle: abort wins.
        @(posedge clk); #1 start3 = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start3 = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("busy3 start+abort", int'(busy3), 0);
        repeat (20) @(negedge clk);
        check("busy3 start+abort later", int'(busy3), 0);

        // Reset in the middle of the first pixel's taps.
        fill(1, 0);
        ker_sel = 3'd0; shift = 4'd0; border = 1'b0;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst busy3", int'(busy3), 0);
        check("rst done3", int'(done3), 0);
        check("rst out_we3", int'(m3.out_we), 0);
        check("rst out_x3", int'(m3.out_x), 0);
        check("rst out_y3", int'(m3.out_y), 0);
        check("rst out_pix3", int'(m3.out_pix), 0);
        check("rst ker_addr3", int'(m3.ker_addr), 0);
        check("rst rd_x3", int'(m3.rd_x), 0);
        check("rst rd_y3", int'(m3.rd_y), 0);
        run_frame(0, 0, 0, 1'b1, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
